// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and baud-divisor helper shared by the UART stages.
package uart_pkg;
  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, PARITY, STOP} state_e;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous input, reset value selectable.
module sync2 #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] ff_d, ff_q;
  always_comb ff_d = rst ? {2{RST_VAL}} : {ff_q[0], d};
  always_ff @(posedge clk) ff_q <= ff_d;
  assign q = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with one-cycle valid/error pulses.
// Define UART_RX_PARITY_EN to add a parity bit (sense from PARITY_ODD) before the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 115200,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  if (CLKS_PER_BIT < 4) begin : g_chk
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end
  logic rxs;
  sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rxs));
  state_e         state_d, state_q;
  logic [CW-1:0]  cnt_d, cnt_q;
  logic [2:0]     idx_d, idx_q;
  logic [7:0]     shift_d, shift_q, data_d, data_q;
  logic           valid_d, valid_q, ferr_d, ferr_q;
  logic           tick, par_ok;
`ifdef UART_RX_PARITY_EN
  localparam state_e LAST = PARITY;
  logic par_d, par_q, perr_d, perr_q;
  assign par_ok = ((^shift_q) ^ par_q) == PARITY_ODD;
  assign parity_err = perr_q;
`else
  localparam state_e LAST = STOP;
  logic unused_cfg;
  assign unused_cfg = PARITY_ODD;
  assign par_ok = 1'b1;
  assign parity_err = 1'b0;
`endif
  assign tick = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? cnt_q : cnt_q - CW'(1);
    idx_d = idx_q;
    shift_d = shift_q;
    data_d = data_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d = par_q;
    perr_d = 1'b0;
`endif
    case (state_q)
      WAIT_HIGH: state_d = rxs ? IDLE : WAIT_HIGH;
      IDLE: if (!rxs) begin
        state_d = START;
        cnt_d = CW'(HALF - 1);
      end
      START: if (tick) begin
        state_d = rxs ? IDLE : DATA;
        cnt_d = CW'(CLKS_PER_BIT - 1);
        idx_d = '0;
      end
      DATA: if (tick) begin
        shift_d = {rxs, shift_q[7:1]};
        cnt_d = CW'(CLKS_PER_BIT - 1);
        idx_d = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? LAST : DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        par_d = rxs;
        cnt_d = CW'(CLKS_PER_BIT - 1);
        state_d = STOP;
      end
`endif
      // Returning to IDLE mid-stop-bit lets a back-to-back start edge be caught.
      STOP: if (tick) begin
        valid_d = rxs && par_ok;
        data_d = (rxs && par_ok) ? shift_q : data_q;
        ferr_d = !rxs;
`ifdef UART_RX_PARITY_EN
        perr_d = !par_ok;
`endif
        state_d = rxs ? IDLE : WAIT_HIGH;
      end
      default: state_d = WAIT_HIGH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_HIGH;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
    end
  end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q <= par_d;
      perr_q <= perr_d;
    end
  end
`endif
  assign rx_valid = valid_q;
  assign rx_data = data_q;
  assign frame_err = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames checked against an event-queue model of the receiver.
module tb_uart_rx;
  localparam int CPB = 8;
  localparam int HALF = CPB / 2;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic rx_valid, frame_err, parity_err;
  logic [7:0] rx_data;
  int checks = 0, failures = 0, cyc = 0;
  bit rst_edge = 1'b0;
  logic [7:0] last_data = 8'h00;
  ev_t exp_q[$];

  uart_rx #(.CLK_HZ(800), .BAUD(100), .PARITY_ODD(PODD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_valid(rx_valid), .rx_data(rx_data),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_edge = rst;
  end

  always @(negedge clk) begin
    if (rst_edge) begin
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_perr", parity_err, 0);
      last_data = 8'h00;
    end else if (rx_valid || frame_err || parity_err) begin
      if (exp_q.size() == 0) chk("unexpected_event", {parity_err, frame_err, rx_valid}, 0);
      else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_kind", {parity_err, frame_err, rx_valid}, e.kind);
        chk("event_cycle", cyc, e.cyc);
        if (e.kind[0]) last_data = e.data;
        chk("rx_data", rx_data, last_data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  // abort >= 0 asserts rst inside that bit slot and expects no event from the frame
  task automatic send(input logic [7:0] d, input bit stop, input bit pflip, input int extra_low, input int abort);
    logic [10:0] bits;
    bit perr;
    ev_t e;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    bits[9 + PAR] = stop;
    if (PAR == 1) bits[9] = (^d) ^ PODD ^ pflip;
    perr = pflip && (PAR == 1);
    if (abort < 0) begin
      e.kind = {perr, !stop, stop && !perr};
      e.data = d;
      e.cyc = cyc + 2 + HALF + (9 + PAR) * CPB + 1;
      exp_q.push_back(e);
    end
    for (int j = 0; j < 10 + PAR; j++)
      for (int k = 0; k < CPB; k++) begin
        rx = bits[j];
        if (j == abort && k == 3) rst = 1'b1;
        if (j == abort && k == 5) rst = 1'b0;
        tick(1);
      end
    if (!stop) begin
      rx = 1'b0;
      tick(extra_low);
    end
    rx = 1'b1;
  endtask

  initial begin
    bit prev_bad;
    tick(3);
    rst = 1'b0;
    idle(2 * CPB);
    send(8'h61, 1, 0, 0, -1);
    idle(CPB);
    send(8'h00, 1, 0, 0, -1);
    send(8'hFF, 1, 0, 0, -1);
    send(8'hA5, 1, 0, 0, -1);
    idle(2 * CPB);
    rx = 1'b0;
    tick(3);
    idle(2 * CPB);
    send(8'h3C, 1, 0, 0, -1);
    idle(CPB);
    send(8'h55, 0, 0, 20, -1);
    idle(CPB);
    send(8'h12, 1, 0, 0, -1);
    idle(CPB);
    send(8'hF5, 1, 0, 0, 5);
    idle(CPB);
    send(8'h7E, 1, 0, 0, -1);
    idle(CPB);
    if (PAR == 1) begin
      send(8'h03, 1, 0, 0, -1);
      idle(CPB);
      send(8'h03, 1, 1, 0, -1);
      idle(CPB);
      send(8'h03, 0, 1, 5, -1);
      idle(CPB);
    end
    prev_bad = 1'b0;
    for (int n = 0; n < 40; n++) begin
      bit stop, pflip;
      stop = $urandom_range(0, 7) != 0;
      pflip = $urandom_range(0, 5) == 0;
      idle(CPB * ($urandom_range(0, 2) + (prev_bad ? 1 : 0)));
      send(8'($urandom), stop, pflip, stop ? 0 : $urandom_range(0, 12), -1);
      prev_bad = !stop;
    end
    idle(3 * CPB);
    chk("pending_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
